// File: rtl/if_branch_predictor_pkg.sv
// rtl/if_branch_predictor_pkg.sv - shared instruction-type and counter encodings for the branch predictor
package if_branch_predictor_pkg;

  localparam logic [3:0] R_IR    = 4'd0;
  localparam logic [3:0] I_IR    = 4'd1;
  localparam logic [3:0] S_IR    = 4'd2;
  localparam logic [3:0] B_IR    = 4'd3;
  localparam logic [3:0] U_IR    = 4'd4;
  localparam logic [3:0] JAL_IR  = 4'd5;
  localparam logic [3:0] JALR_IR = 4'd6;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_STR = 2'b11;

  function automatic logic is_jump_type(input logic [3:0] t);
    return (t == JAL_IR) || (t == JALR_IR);
  endfunction

endpackage

// File: rtl/if_branch_predictor_sat_counter2.sv
// rtl/if_branch_predictor_sat_counter2.sv - 2-bit saturating counter next-state function
module sat_counter2
  import if_branch_predictor_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_STR) ctr_o = ctr_i + 2'd1;
    end else begin
      if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'd1;
    end
  end

endmodule

// File: rtl/if_branch_predictor.sv
// rtl/if_branch_predictor.sv - direct-mapped BTB with 2-bit counters, combinational IF-stage lookup
module if_branch_predictor
  import if_branch_predictor_pkg::*;
#(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        jump_prediction,
  output logic [31:0] addr_prediction,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [3:0]  update_ir_type,
  input  logic        update_taken,
  input  logic [31:0] update_target
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 30 - INDEX_BITS;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [TAG_W-1:0]      lk_tag;
  logic                  lk_hit;

  logic [INDEX_BITS-1:0] up_idx;
  logic [TAG_W-1:0]      up_tag;
  logic                  up_hit;
  logic                  up_jump;
  logic                  up_branch;
  logic                  wr_entry;
  logic                  wr_target;
  logic [1:0]            ctr_nxt;
  logic [1:0]            ctr_d;

  wire unused_low_bits = ^{pc[1:0], update_pc[1:0]};

  assign lk_idx = pc[INDEX_BITS+1:2];
  assign lk_tag = pc[31:INDEX_BITS+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign jump_prediction = lk_hit && ctr_q[lk_idx][1];
  assign addr_prediction = jump_prediction ? target_q[lk_idx] : pc + 32'd4;

  assign up_idx = update_pc[INDEX_BITS+1:2];
  assign up_tag = update_pc[31:INDEX_BITS+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  sat_counter2 u_sat_counter2 (
    .ctr_i   (ctr_q[up_idx]),
    .taken_i (update_taken),
    .ctr_o   (ctr_nxt)
  );

  // An untaken branch that misses must leave the occupant alone, so it never writes.
  always_comb begin
    up_jump   = is_jump_type(update_ir_type);
    up_branch = (update_ir_type == B_IR);
    wr_entry  = update_en && (up_jump || (up_branch && (up_hit || update_taken)));
    wr_target = wr_entry && (up_jump || update_taken);
    ctr_d     = CTR_WT;
    if (up_jump) begin
      ctr_d = CTR_STR;
    end else if (up_hit) begin
      ctr_d = ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WNT;
      end
    end else if (wr_entry) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= ctr_d;
    end
  end

  // Tag and target carry no reset; reset still blocks a simultaneous write.
  always_ff @(posedge clk) begin
    if (rst_n && wr_entry) begin
      tag_q[up_idx] <= up_tag;
    end
    if (rst_n && wr_target) begin
      target_q[up_idx] <= update_target;
    end
  end

endmodule

// File: tb/tb_if_branch_predictor.sv
// tb/tb_if_branch_predictor.sv - directed vector testbench for if_branch_predictor
module tb_if_branch_predictor;
  import if_branch_predictor_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        jump_prediction;
  logic [31:0] addr_prediction;
  logic        update_en;
  logic [31:0] update_pc;
  logic [3:0]  update_ir_type;
  logic        update_taken;
  logic [31:0] update_target;

  int checks;
  int errors;

  if_branch_predictor #(.INDEX_BITS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc              (pc),
    .jump_prediction (jump_prediction),
    .addr_prediction (addr_prediction),
    .update_en       (update_en),
    .update_pc       (update_pc),
    .update_ir_type  (update_ir_type),
    .update_taken    (update_taken),
    .update_target   (update_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic [31:0] upc;
    logic [3:0]  ty;
    logic        tk;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        chk;
    logic        ej;
    logic [31:0] ea;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic en, input logic [31:0] upc, input logic [3:0] ty,
                     input logic tk, input logic [31:0] tgt, input logic [31:0] lpc,
                     input logic chk, input logic ej, input logic [31:0] ea);
    vec_t v;
    v.rst_n = r; v.en = en; v.upc = upc; v.ty = ty; v.tk = tk; v.tgt = tgt;
    v.pc = lpc; v.chk = chk; v.ej = ej; v.ea = ea;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n          = v.rst_n;
    update_en      = v.en;
    update_pc      = v.upc;
    update_ir_type = v.ty;
    update_taken   = v.tk;
    update_target  = v.tgt;
    pc             = v.pc;
  endtask

  initial begin
    vec_t idle;
    checks = 0;
    errors = 0;
    rst_n = 1'b0; update_en = 1'b0; update_pc = '0; update_ir_type = R_IR;
    update_taken = 1'b0; update_target = '0; pc = '0;

    //   rst en  upc           type     tk  tgt           lookup pc     chk ej  ea
    add(0, 0, 32'h0,        R_IR,    0, 32'h0,        32'h100,      0, 0, 32'h0);
    add(1, 1, 32'h100,      JAL_IR,  1, 32'h200,      32'h100,      1, 0, 32'h104);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h100,      1, 1, 32'h200);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h140,      1, 0, 32'h144);
    add(1, 1, 32'h140,      B_IR,    0, 32'h300,      32'h100,      1, 1, 32'h200);
    add(1, 1, 32'h140,      B_IR,    1, 32'h300,      32'h100,      1, 1, 32'h200);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h100,      1, 0, 32'h104);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h140,      1, 1, 32'h300);
    add(1, 1, 32'h100,      JAL_IR,  1, 32'h240,      32'h100,      1, 0, 32'h104);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h100,      1, 1, 32'h240);
    add(1, 1, 32'h80,       B_IR,    1, 32'h180,      32'h80,       1, 0, 32'h84);
    add(1, 1, 32'h80,       B_IR,    1, 32'h180,      32'h80,       1, 1, 32'h180);
    add(1, 1, 32'h80,       B_IR,    0, 32'h180,      32'h80,       1, 1, 32'h180);
    add(1, 1, 32'h80,       B_IR,    0, 32'h180,      32'h80,       1, 1, 32'h180);
    add(1, 1, 32'h80,       B_IR,    0, 32'h180,      32'h80,       1, 0, 32'h84);
    add(1, 1, 32'h80,       B_IR,    0, 32'h180,      32'h80,       1, 0, 32'h84);
    add(1, 1, 32'h80,       B_IR,    1, 32'h1c0,      32'h80,       1, 0, 32'h84);
    add(1, 1, 32'h80,       B_IR,    1, 32'h1c0,      32'h80,       1, 0, 32'h84);
    add(1, 1, 32'h80,       R_IR,    1, 32'h500,      32'h80,       1, 1, 32'h1c0);
    add(1, 0, 32'h40,       B_IR,    1, 32'h600,      32'h80,       1, 1, 32'h1c0);
    add(1, 1, 32'h44,       JALR_IR, 1, 32'h1000,     32'h40,       1, 0, 32'h44);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h44,       1, 1, 32'h1000);
    add(0, 1, 32'h8,        JAL_IR,  1, 32'h900,      32'h80,       1, 1, 32'h1c0);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h80,       1, 0, 32'h84);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h8,        1, 0, 32'hc);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'h44,       1, 0, 32'h48);
    add(1, 0, 32'h0,        R_IR,    0, 32'h0,        32'hfffffffc, 1, 0, 32'h0);

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      if (vecs[i].chk) begin
        check($sformatf("vec%0d_jump", i), {31'd0, jump_prediction}, {31'd0, vecs[i].ej});
        check($sformatf("vec%0d_addr", i), addr_prediction, vecs[i].ea);
      end
      @(posedge clk);
      #1;
    end

    // Fetch stall: train a JAL, then hold pc for several cycles with no updates.
    idle = vecs[2];
    drive(vecs[1]);
    @(posedge clk);
    #1;
    drive(idle);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_jump", k), {31'd0, jump_prediction}, 32'd1);
      check($sformatf("stall%0d_addr", k), addr_prediction, 32'h200);
      @(posedge clk);
      #1;
    end

    // Reset held for two edges with an update pending: still nothing learned.
    rst_n = 1'b0; update_en = 1'b1; update_pc = 32'h100; update_ir_type = JAL_IR;
    update_taken = 1'b1; update_target = 32'h700; pc = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; update_en = 1'b0;
    @(negedge clk);
    check("rst_hold_jump", {31'd0, jump_prediction}, 32'd0);
    check("rst_hold_addr", addr_prediction, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_branch_predictor.md
# if_branch_predictor

IF-stage branch predictor: a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It produces `jump_prediction` and `addr_prediction` for the fetch PC; the EX-stage jump resolution checks these and redirects fetch on a mispredict. EX writes the resolved outcome back through the update port, which keeps the BTB trained.

## Interface
- `INDEX_BITS`, 4: BTB index width; the BTB has 2^INDEX_BITS entries.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `pc`  in  32  current fetch PC, word-aligned.
- `jump_prediction`  out  1  predicted taken.
- `addr_prediction`  out  32  predicted next PC.
- `update_en`  in  1  EX resolved a control-transfer instruction this cycle. EX already deasserts it for flushed instructions.
- `update_pc`  in  32  PC of the resolved instruction.
- `update_ir_type`  in  4  ir_type of the resolved instruction.
- `update_taken`  in  1  actual jump outcome.
- `update_target`  in  32  actual target address.

## Operation
- Address split:
  - index = `pc[INDEX_BITS+1:2]`
  - tag = `pc[31:INDEX_BITS+2]`
  - The same split applies to `update_pc`.
- Each entry holds `valid`, `tag`, a 32-bit `target` and a 2-bit `ctr`.
  - `ctr` states: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from the registered array:
  - hit = `valid && tag match`.
  - `jump_prediction` = hit && `ctr[1]`.
  - `addr_prediction` = `target` if `jump_prediction`, otherwise `pc + 4` (mod 2^32).
- Update is applied at the `clk` edge when `update_en` = 1.
  - Ignored unless `update_ir_type` is `JAL_IR`, `JALR_IR` or `B_IR`.
- JAL/JALR:
  - Write `valid`=1, the tag and `target`=`update_target`, with `ctr`=11.
  - This happens whether the access hits or misses.
- Branch, hit:
  - Taken: `ctr` increments, saturating at 11, and `target` is rewritten.
  - Not taken: `ctr` decrements, saturating at 00, and `target` is unchanged.
- Branch, miss:
  - Taken: allocate the entry, overwriting any occupant, with `ctr`=10 and `target`=`update_target`.
  - Not taken: no change, so an untaken branch never evicts an entry.
- Counter arithmetic is 2-bit saturating and never wraps.

## Timing
- Lookup latency is 0 cycles; the outputs depend combinationally on `pc` and the array state.
- An update takes effect at the edge that samples it and becomes visible to lookups in the following cycle.
- Lookup and update to the same index in the same cycle: the lookup sees the pre-update contents. There is no bypass.
- Reset (`rst_n`=0 at an edge):
  - All `valid` bits clear and all `ctr` go to 01. `tag` and `target` need not be reset.
  - After reset, `jump_prediction`=0 and `addr_prediction`=`pc+4` for any `pc`.
- Reset has priority over a simultaneous update, which is dropped. Asserting reset mid-run discards all training.
- There is no stall input. Fetch stalls hold `pc`, and the outputs stay stable because the array only changes on updates.

## Structure
- `JAL_IR`, `JALR_IR` and `B_IR` come from the shared `constants/ir_type.v`.
- Counter state encodings go in a new shared header, `constants/bp_ctr.v`: `CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_STR`.
- One sub-module, `sat_counter2`: a combinational next-state function taking `ctr` and a taken bit and returning the saturated counter.
- The array is written as flops with a synchronous reset of valid/ctr.

## Test plan
- Reset, then lookup `pc`=0x100 -> `jump_prediction`=0, `addr_prediction`=0x104.
- JAL update with `update_pc`=0x100, `update_target`=0x200; next cycle lookup 0x100 -> prediction 1, 0x200. Lookup 0x140 (INDEX_BITS=4: same index, different tag) -> 0, 0x144.
- Branch at 0x80, taken twice, then not taken three times:
  - `ctr` sequence 10 → 11 → 10 → 01 → 00.
  - Predictions after each update: 1, 1, 1, 0, 0.
  - The fourth not-taken update holds `ctr` at 00.
- Untaken branch miss at 0x140 while 0x100 is valid -> 0x100 still predicts 0x200. A taken branch at 0x140 then evicts it -> 0x100 predicts 0, 0x104.
- Update and lookup of 0x100 in the same cycle -> the old prediction is shown that cycle and the new one the next. `rst_n`=0 together with `update_en`=1 -> the update is dropped and all lookups predict not taken.
